// File: rtl/memacc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memacc_pkg                                                           |
// | Shared types and limits for the memory-access pipeline stage.        |
// | Rev 1.0 - initial parametrised release                               |
// +----------------------------------------------------------------------+
package memacc_pkg;

  localparam int MEMACC_MIN_LATENCY = 2;
  localparam int MEMACC_MAX_LATENCY = 16;
  localparam int CNT_W              = $clog2(MEMACC_MAX_LATENCY);

  // Field widths of the canonical payload bundle held across a memory wait.
  localparam int MEMACC_DATA_W     = 32;
  localparam int MEMACC_SIDEBAND_W = 48;
  localparam int MEMACC_PC_W       = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memacc_state_t;

  typedef struct packed {
    logic [MEMACC_DATA_W-1:0]     alu_result;
    logic [MEMACC_DATA_W-1:0]     store_data;
    logic [MEMACC_SIDEBAND_W-1:0] sideband;
    logic [MEMACC_PC_W-1:0]       pc;
    logic [MEMACC_PC_W-1:0]       pc1;
    logic [MEMACC_PC_W-1:0]       pc2;
  } memacc_payload_t;

endpackage
`default_nettype wire

// File: rtl/memory_access_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_access_pipe_if                                                |
// | Upstream, downstream and data-memory signals of the stage.           |
// | Rev 1.0 - initial parametrised release                               |
// +----------------------------------------------------------------------+
interface memory_access_pipe_if #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int DATA_W         = 32,
  parameter int SIDEBAND_W     = 48
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      mem_read;
  logic                      mem_write;
  logic [DATA_W-1:0]         alu_result;
  logic [DATA_W-1:0]         store_data;
  logic [SIDEBAND_W-1:0]     sideband;
  logic [INST_MEM_WIDTH-1:0] pc;
  logic [INST_MEM_WIDTH-1:0] pc1;
  logic [INST_MEM_WIDTH-1:0] pc2;
  logic                      out_valid;
  logic [DATA_W-1:0]         alu_result_next;
  logic [DATA_W-1:0]         store_data_next;
  logic [SIDEBAND_W-1:0]     sideband_next;
  logic [INST_MEM_WIDTH-1:0] pc_next;
  logic [INST_MEM_WIDTH-1:0] pc1_next;
  logic [INST_MEM_WIDTH-1:0] pc2_next;
  logic [DATA_W-1:0]         read_data;
  logic                      dm_req;
  logic                      dm_we;
  logic [DATA_W-1:0]         dm_addr;
  logic [DATA_W-1:0]         dm_wdata;
  logic [DATA_W-1:0]         dm_rdata;

  // Upstream producer plus data memory.
  modport master (
    output in_valid, mem_read, mem_write, alu_result, store_data, sideband,
           pc, pc1, pc2, dm_rdata,
    input  in_ready, out_valid, alu_result_next, store_data_next, sideband_next,
           pc_next, pc1_next, pc2_next, read_data, dm_req, dm_we, dm_addr, dm_wdata
  );

  // The pipeline stage itself.
  modport slave (
    input  in_valid, mem_read, mem_write, alu_result, store_data, sideband,
           pc, pc1, pc2, dm_rdata,
    output in_ready, out_valid, alu_result_next, store_data_next, sideband_next,
           pc_next, pc1_next, pc2_next, read_data, dm_req, dm_we, dm_addr, dm_wdata
  );
endinterface
`default_nettype wire

// File: rtl/memacc_wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memacc_wait_counter                                                  |
// | Loadable down counter with zero flag; saturates at zero.             |
// | Rev 1.0 - initial parametrised release                               |
// +----------------------------------------------------------------------+
module memacc_wait_counter #(
  parameter int W = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_load,
  input  wire logic [W-1:0] i_load_value,
  input  wire logic         i_dec,
  output logic              o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/memory_access_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_access_pipe                                                   |
// | Execute->write-back memory stage with configurable memory latency.   |
// | Option macro: MEMACC_POSTED_STORE_EN (stores complete in one cycle). |
// | Rev 1.0 - initial parametrised release                               |
// +----------------------------------------------------------------------+
module memory_access_pipe
  import memacc_pkg::*;
#(
  parameter int INST_MEM_WIDTH = MEMACC_PC_W,
  parameter int DATA_W         = MEMACC_DATA_W,
  parameter int SIDEBAND_W     = MEMACC_SIDEBAND_W,
  parameter int MEM_LATENCY    = 3
) (
  input  wire logic           CLK,
  input  wire logic           reset,
  memory_access_pipe_if.slave bus
);

  if ((MEM_LATENCY < MEMACC_MIN_LATENCY) || (MEM_LATENCY > MEMACC_MAX_LATENCY)) begin : g_bad_latency
    $error("memory_access_pipe: MEM_LATENCY out of range 2..16");
  end
  if ((DATA_W != MEMACC_DATA_W) || (SIDEBAND_W != MEMACC_SIDEBAND_W) ||
      (INST_MEM_WIDTH != MEMACC_PC_W)) begin : g_bad_width
    $error("memory_access_pipe: field widths must match memacc_payload_t");
  end

  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(MEM_LATENCY - 2);

  memacc_state_t   r_state;
  memacc_state_t   w_state_next;
  memacc_payload_t w_payload_in;
  memacc_payload_t r_hold;
  memacc_payload_t r_payload_next;
  logic            r_hold_load;
  logic            r_out_valid;
  logic [DATA_W-1:0] r_read_data;
  logic            w_accept;
  logic            w_is_mem;
  logic            w_wait_op;
  logic            w_cnt_load;
  logic            w_cnt_dec;
  logic            w_cnt_zero;
  logic            w_complete;

  // Reset forces in_ready low so every output reads zero while it is held.
  assign bus.in_ready = (r_state == IDLE) && !reset;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_is_mem     = bus.mem_read || bus.mem_write;

`ifdef MEMACC_POSTED_STORE_EN
  assign w_wait_op = bus.mem_read && !bus.mem_write;
`else
  assign w_wait_op = w_is_mem;
`endif

  assign bus.dm_req   = w_accept && w_is_mem;
  assign bus.dm_we    = bus.dm_req && bus.mem_write;
  assign bus.dm_addr  = {DATA_W{bus.dm_req}} & bus.alu_result;
  assign bus.dm_wdata = {DATA_W{bus.dm_req}} & bus.store_data;

  assign w_payload_in = '{alu_result: bus.alu_result, store_data: bus.store_data,
                          sideband: bus.sideband, pc: bus.pc, pc1: bus.pc1, pc2: bus.pc2};

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_wait_op) begin
          w_state_next = WAIT;
          w_cnt_load   = 1'b1;
        end
      end
      WAIT: begin
        if (w_cnt_zero) begin
          w_state_next = IDLE;
          w_complete   = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
    endcase
  end

  memacc_wait_counter #(
    .W (CNT_W)
  ) u_wait_counter (
    .clk          (CLK),
    .rst          (reset),
    .i_load       (w_cnt_load),
    .i_load_value (c_cnt_init),
    .i_dec        (w_cnt_dec),
    .o_zero       (w_cnt_zero)
  );

  // Both-set read/write behaves as a store, so only a pure read is a load.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_hold_load <= 1'b0;
    end else if (w_cnt_load) begin
      r_hold      <= w_payload_in;
      r_hold_load <= bus.mem_read && !bus.mem_write;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_payload_next <= '0;
      r_read_data    <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept && !w_wait_op) begin
        r_out_valid    <= 1'b1;
        r_payload_next <= w_payload_in;
      end else if (w_complete) begin
        r_out_valid    <= 1'b1;
        r_payload_next <= r_hold;
        if (r_hold_load) begin
          r_read_data <= bus.dm_rdata;
        end
      end
    end
  end

  assign bus.out_valid       = r_out_valid;
  assign bus.alu_result_next = r_payload_next.alu_result;
  assign bus.store_data_next = r_payload_next.store_data;
  assign bus.sideband_next   = r_payload_next.sideband;
  assign bus.pc_next         = r_payload_next.pc;
  assign bus.pc1_next        = r_payload_next.pc1;
  assign bus.pc2_next        = r_payload_next.pc2;
  assign bus.read_data       = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memory_access_pipe                                                |
// | Directed bench; instance g_dut[i] runs with MEM_LATENCY = i + 2.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_memory_access_pipe;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_rd = 1'b0;
  logic        s_wr = 1'b0;
  logic [31:0] s_alu = '0;
  logic [31:0] s_sd = '0;
  logic [47:0] s_sb = '0;
  logic [1:0]  s_pc = '0;
  logic [1:0]  s_pc1 = '0;
  logic [1:0]  s_pc2 = '0;
  logic [31:0] s_rdata = '0;
  int          total = 0;
  int          bad = 0;
  int          req_cnt0 = 0;

  always #5 CLK = ~CLK;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    memory_access_pipe_if #(.INST_MEM_WIDTH(2), .DATA_W(32), .SIDEBAND_W(48)) bus ();
    assign bus.in_valid   = s_valid;
    assign bus.mem_read   = s_rd;
    assign bus.mem_write  = s_wr;
    assign bus.alu_result = s_alu;
    assign bus.store_data = s_sd;
    assign bus.sideband   = s_sb;
    assign bus.pc         = s_pc;
    assign bus.pc1        = s_pc1;
    assign bus.pc2        = s_pc2;
    assign bus.dm_rdata   = s_rdata;
    memory_access_pipe #(
      .INST_MEM_WIDTH (2),
      .DATA_W         (32),
      .SIDEBAND_W     (48),
      .MEM_LATENCY    (i + 2)
    ) u_dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
    );
  end

  always @(posedge CLK) if (g_dut[0].bus.dm_req === 1'b1) req_cnt0 <= req_cnt0 + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] sd);
    s_valid = v; s_rd = rd; s_wr = wr; s_alu = alu; s_sd = sd;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  // Steps until instance 1 (latency 3) pulses out_valid; returns steps taken, 0 on timeout.
  task automatic wait_ov1(output int n);
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (g_dut[1].bus.out_valid === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int req_base;

    // Reset state
    step();
    chk("rst_out_valid", g_dut[1].bus.out_valid, 1'b0);
    chk("rst_in_ready", g_dut[1].bus.in_ready, 1'b0);
    chk("rst_read_data", g_dut[1].bus.read_data, 32'h0);
    chk("rst_alu_next", g_dut[1].bus.alu_result_next, 32'h0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", g_dut[1].bus.in_ready, 1'b1);

    // Non-memory op, latency 3
    s_sb = 48'h0000_ABCD_0001; s_pc = 2'd1; s_pc1 = 2'd2; s_pc2 = 2'd3;
    drive(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h55);
    #1;
    chk("nm_dm_req", g_dut[1].bus.dm_req, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("nm_out_valid", g_dut[1].bus.out_valid, 1'b1);
    chk("nm_alu_next", g_dut[1].bus.alu_result_next, 32'h0000_1234);
    chk("nm_sb_next", g_dut[1].bus.sideband_next, 48'h0000_ABCD_0001);
    chk("nm_pc2_next", g_dut[1].bus.pc2_next, 2'd3);
    chk("nm_read_data", g_dut[1].bus.read_data, 32'h0);
    step();
    chk("nm_pulse", g_dut[1].bus.out_valid, 1'b0);
    chk("nm_hold", g_dut[1].bus.alu_result_next, 32'h0000_1234);

    // Load at 0x40, latency 3
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    s_rdata = 32'h1111_1111;
    #1;
    chk("ld_dm_req", g_dut[1].bus.dm_req, 1'b1);
    chk("ld_dm_we", g_dut[1].bus.dm_we, 1'b0);
    chk("ld_dm_addr", g_dut[1].bus.dm_addr, 32'h40);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ld_t1_ready", g_dut[1].bus.in_ready, 1'b0);
    chk("ld_t1_ov", g_dut[1].bus.out_valid, 1'b0);
    step();
    s_rdata = 32'hDEAD_BEEF;
    chk("ld_t2_ready", g_dut[1].bus.in_ready, 1'b0);
    chk("ld_t2_ov", g_dut[1].bus.out_valid, 1'b0);
    step();
    s_rdata = 32'h0;
    chk("ld_t3_ov", g_dut[1].bus.out_valid, 1'b1);
    chk("ld_t3_rdata", g_dut[1].bus.read_data, 32'hDEAD_BEEF);
    chk("ld_t3_alu_next", g_dut[1].bus.alu_result_next, 32'h40);
    chk("ld_t3_ready", g_dut[1].bus.in_ready, 1'b1);
    step();
    chk("ld_t4_ov", g_dut[1].bus.out_valid, 1'b0);
    chk("ld_t4_rdata_hold", g_dut[1].bus.read_data, 32'hDEAD_BEEF);

    // Store 0xCAFEBABE to 0x80 then a non-memory op, latency 5
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 32'h80, 32'hCAFE_BABE);
    #1;
    chk("st_dm_req", g_dut[3].bus.dm_req, 1'b1);
    chk("st_dm_we", g_dut[3].bus.dm_we, 1'b1);
    chk("st_dm_wdata", g_dut[3].bus.dm_wdata, 32'hCAFE_BABE);
    chk("st_dm_addr", g_dut[3].bus.dm_addr, 32'h80);
    step();
`ifdef MEMACC_POSTED_STORE_EN
    chk("pst_t1_ov", g_dut[3].bus.out_valid, 1'b1);
    chk("pst_t1_alu_next", g_dut[3].bus.alu_result_next, 32'h80);
    chk("pst_t1_ready", g_dut[3].bus.in_ready, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h777, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("pst_t2_ov", g_dut[3].bus.out_valid, 1'b1);
    chk("pst_t2_alu_next", g_dut[3].bus.alu_result_next, 32'h777);
`else
    drive(1'b1, 1'b0, 1'b0, 32'h777, 32'h0);
    #1;
    chk("st_t1_ready", g_dut[3].bus.in_ready, 1'b0);
    chk("st_t1_dm_req", g_dut[3].bus.dm_req, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("st_stall_ready", g_dut[3].bus.in_ready, 1'b0);
      chk("st_stall_ov", g_dut[3].bus.out_valid, 1'b0);
    end
    step();
    chk("st_t5_ov", g_dut[3].bus.out_valid, 1'b1);
    chk("st_t5_alu_next", g_dut[3].bus.alu_result_next, 32'h80);
    chk("st_t5_sd_next", g_dut[3].bus.store_data_next, 32'hCAFE_BABE);
    chk("st_t5_rdata", g_dut[3].bus.read_data, 32'h0);
    chk("st_t5_ready", g_dut[3].bus.in_ready, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("st_t6_ov", g_dut[3].bus.out_valid, 1'b1);
    chk("st_t6_alu_next", g_dut[3].bus.alu_result_next, 32'h777);
`endif

    // Back-to-back loads, latency 2
    do_reset();
    req_base = req_cnt0;
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    s_rdata = 32'h0BAD_0000;
    #1;
    chk("bb_t0_req", g_dut[0].bus.dm_req, 1'b1);
    step();
    s_alu = 32'h104;
    s_rdata = 32'hA1A1_0001;
    #1;
    chk("bb_t1_req", g_dut[0].bus.dm_req, 1'b0);
    chk("bb_t1_ready", g_dut[0].bus.in_ready, 1'b0);
    step();
    s_rdata = 32'h0BAD_0001;
    chk("bb_t2_ov", g_dut[0].bus.out_valid, 1'b1);
    chk("bb_t2_rdata", g_dut[0].bus.read_data, 32'hA1A1_0001);
    chk("bb_t2_req", g_dut[0].bus.dm_req, 1'b1);
    chk("bb_t2_addr", g_dut[0].bus.dm_addr, 32'h104);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_rdata = 32'hA2A2_0002;
    chk("bb_t3_ov", g_dut[0].bus.out_valid, 1'b0);
    step();
    s_rdata = 32'h0;
    chk("bb_t4_ov", g_dut[0].bus.out_valid, 1'b1);
    chk("bb_t4_rdata", g_dut[0].bus.read_data, 32'hA2A2_0002);
    chk("bb_t4_alu_next", g_dut[0].bus.alu_result_next, 32'h104);
    step();
    chk("bb_req_count", 64'(req_cnt0 - req_base), 64'd2);

    // Read and write together act as a store, latency 3
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    s_rdata = 32'h1234_5678;
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_ov1(n);
    chk("rw_pre_latency", 64'(n + 1), 64'd3);
    chk("rw_pre_rdata", g_dut[1].bus.read_data, 32'h1234_5678);
    drive(1'b1, 1'b1, 1'b1, 32'h90, 32'h5A5A);
    #1;
    chk("rw_dm_req", g_dut[1].bus.dm_req, 1'b1);
    chk("rw_dm_we", g_dut[1].bus.dm_we, 1'b1);
    s_rdata = 32'hFFFF_FFFF;
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef MEMACC_POSTED_STORE_EN
    chk("rw_t1_ov", g_dut[1].bus.out_valid, 1'b1);
`else
    chk("rw_t1_ov", g_dut[1].bus.out_valid, 1'b0);
    wait_ov1(n);
    chk("rw_latency", 64'(n + 1), 64'd3);
`endif
    chk("rw_alu_next", g_dut[1].bus.alu_result_next, 32'h90);
    chk("rw_rdata_kept", g_dut[1].bus.read_data, 32'h1234_5678);
    s_rdata = 32'h0;

    // Reset in the middle of a latency-4 load
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h3C, 32'h0);
    step();
    chk("ra_nm_alu_next", g_dut[2].bus.alu_result_next, 32'h3C);
    drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
    s_rdata = 32'h77;
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ra_t1_ready", g_dut[2].bus.in_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("ra_async_alu_next", g_dut[2].bus.alu_result_next, 32'h0);
    chk("ra_async_ready", g_dut[2].bus.in_ready, 1'b0);
    chk("ra_async_ov", g_dut[2].bus.out_valid, 1'b0);
    step();
    reset = 1'b0;
    #1;
    chk("ra_rel_ready", g_dut[2].bus.in_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("ra_no_ov", g_dut[2].bus.out_valid, 1'b0);
      chk("ra_no_req", g_dut[2].bus.dm_req, 1'b0);
    end
    chk("ra_rdata", g_dut[2].bus.read_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/memory_access_pipe.md
Name: memory_access_pipe

Overview:
- Parametrised successor to the fixed 3-cycle memory-access pipeline stage; sits between execute and write-back.
- Non-memory ops pass through in one cycle. Loads and stores issue one request to an external data memory, then wait a configurable latency.
- Upstream stalls through a ready handshake. The memory is a port-level interface, not an internal instance.

Parameters:
- INST_MEM_WIDTH, 2, width of each carried PC field.
- DATA_W, 32, width of data, address and ALU result.
- SIDEBAND_W, 48, opaque control bundle carried unchanged (RegWrite, MemtoReg, Branch, UARTtoReg, AorF, rdist, inst_index packed by the instantiator).
- MEM_LATENCY, 3, cycles from request to completion. Legal range 2..16; elaboration error outside it.

Ports:
- CLK  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction valid (the old "distinct").
- in_ready  out  1  stage can accept this cycle.
- mem_read  in  1  load.
- mem_write  in  1  store.
- alu_result  in  DATA_W  address, or ALU result for non-memory ops.
- store_data  in  DATA_W  store data.
- sideband  in  SIDEBAND_W  carried control.
- pc, pc1, pc2  in  INST_MEM_WIDTH each  carried PCs.
- out_valid  out  1  result valid pulse.
- alu_result_next, store_data_next  out  DATA_W  carried values.
- sideband_next  out  SIDEBAND_W.
- pc_next, pc1_next, pc2_next  out  INST_MEM_WIDTH.
- read_data  out  DATA_W  load result.
- dm_req  out  1  memory request strobe.
- dm_we  out  1  write enable.
- dm_addr, dm_wdata  out  DATA_W.
- dm_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; counter 0; internal holding registers 0.
- States:
  - IDLE: in_ready=1.
  - WAIT: in_ready=0; counter running.
- Accept: in_valid && in_ready at edge T.
  - Non-memory op (mem_read=0, mem_write=0): payload registered to *_next; out_valid=1 in cycle T+1; stay IDLE.
  - Memory op:
    - Combinationally in cycle T: dm_req=1, dm_we=mem_write, dm_addr=alu_result, dm_wdata=store_data.
    - At edge T: payload captured into holding registers, counter loaded with MEM_LATENCY-2, go WAIT.
- WAIT:
  - counter != 0: decrement.
  - counter == 0:
    - Load: sample dm_rdata into read_data.
    - Copy holding registers to *_next; out_valid=1 next cycle; go IDLE.
  - Net: out_valid in cycle T+MEM_LATENCY. dm_rdata must be valid in cycle T+MEM_LATENCY-1.
  - MEM_LATENCY=3 reproduces the legacy timing.
- out_valid is a one-cycle pulse. *_next and read_data hold their last values otherwise.
- read_data updates only on load completion; unchanged on stores and non-memory ops.
- dm_req=0 in every cycle without an accepted memory op. dm_addr, dm_wdata and dm_we are don't-care when dm_req=0 but must be glitch-free registered-input derived.
- mem_read && mem_write together: treated as a store (dm_we=1, no read_data update).
- in_valid while in_ready=0: ignored. Upstream holds the instruction.
- Back-to-back: a new op is accepted in the same cycle the previous completion's out_valid is being set up (edge leaving WAIT → IDLE, next edge accepts). Load throughput is one per MEM_LATENCY cycles.
- Reset mid-WAIT: abort immediately, no out_valid, no further dm_req.

Optional Feature:
- Macro MEMACC_POSTED_STORE_EN.
- Defined: stores are posted. dm_req is issued in cycle T as above, but the stage stays IDLE and out_valid asserts at T+1 like a non-memory op. Loads are unchanged.
- Not defined: stores wait the full MEM_LATENCY like loads.

Decomposition:
- Package memacc_pkg:
  - state enum (IDLE, WAIT).
  - constants MEMACC_MIN_LATENCY=2, MEMACC_MAX_LATENCY=16.
  - localparam CNT_W=$clog2(MEMACC_MAX_LATENCY).
  - packed struct memacc_payload_t (alu_result, store_data, sideband, pc, pc1, pc2), used for the holding registers.
- Sub-module: memacc_wait_counter. Load/decrement/zero-flag down counter with async reset.

Test Plan:
- Reset, then a non-memory op with alu_result=0x0000_1234 → out_valid at T+1, alu_result_next=0x1234, dm_req never high, read_data=0.
- MEM_LATENCY=3, load at address 0x40, model returns 0xDEADBEEF at T+2 → dm_req=1, dm_we=0 at T; in_ready=0 at T+1..T+2; out_valid at T+3; read_data=0xDEADBEEF.
- MEM_LATENCY=5, store 0xCAFEBABE to 0x80 followed immediately by a non-memory op → dm_we=1, dm_wdata=0xCAFEBABE; second op stalled until T+5. With MEMACC_POSTED_STORE_EN: store out_valid at T+1, second op out_valid at T+2.
- Load then load back-to-back, MEM_LATENCY=2 → exactly 2 dm_req pulses 2 cycles apart; out_valid at T+2 and T+4; read_data matches each.
- mem_read=1, mem_write=1 together → dm_we=1; read_data unchanged from its previous value.
- Reset asserted at T+1 of a MEM_LATENCY=4 load → all outputs 0 asynchronously; no out_valid after release; in_ready=1 next cycle.
